// File: rtl/harmonic_pkg.sv
// harmonic_pkg: shared constants, FSM state encoding, weight-profile codes and small helpers
// for the harmonic scheduler.
//
// Related build option: HARMONIC_OVERRUN_FLAG_EN (used in harmonic_scheduler) adds a sticky
// overrun output.
package harmonic_pkg;

    localparam int unsigned NUM_HARM = 3;   // voices per sample; weight table sized for 3
    localparam int unsigned PHASE_W  = 22;  // [21:20] quadrant, [19:10] address, [9:0] fraction
    localparam int unsigned STEP_W   = 20;
    localparam int unsigned ROM_AW   = 10;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned ACC_W    = 18;

    // Sequential encoding so the voice steps advance by +1.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ADDR0 = 3'd1;
    localparam state_t ST_CAP0  = 3'd2;
    localparam state_t ST_ADDR1 = 3'd3;
    localparam state_t ST_CAP1  = 3'd4;
    localparam state_t ST_ADDR2 = 3'd5;
    localparam state_t ST_CAP2  = 3'd6;
    localparam state_t ST_DONE  = 3'd7;

    // Weight profiles, terms for voices 0/1/2.
    localparam logic [1:0] WGT_FUND  = 2'd0;  // 1,   0,   0
    localparam logic [1:0] WGT_EVEN  = 2'd1;  // 1/2, 1/4, 1/4
    localparam logic [1:0] WGT_SOFT  = 2'd2;  // 5/8, 1/4, 1/8
    localparam logic [1:0] WGT_OCT   = 2'd3;  // 1/4, 1/2, 1/4

    localparam logic signed [ACC_W-1:0] SAT_MAX = 18'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -18'sd32767;

    // Odd quadrants walk the quarter wave backwards.
    function automatic logic [ROM_AW-1:0] quad_addr(input logic q_odd,
                                                    input logic [ROM_AW-1:0] a);
        return q_odd ? ~a : a;
    endfunction

    function automatic logic [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        if (a > SAT_MAX) begin
            r = SAT_MAX;
        end else if (a < SAT_MIN) begin
            r = SAT_MIN;
        end else begin
            r = a;
        end
        return r[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/harmonic_weight.sv
// harmonic_weight: combinational shift-add weighting of one signed voice term.
//   term_i      signed 18-bit term after quadrant sign
//   voice_i     voice index 0..2 (3 yields 0)
//   profile_i   weight profile select
//   weighted_o  weighted signed 18-bit term (arithmetic shifts, floor truncation)
module harmonic_weight
    import harmonic_pkg::*;
(
    input  logic signed [ACC_W-1:0] term_i,
    input  logic        [1:0]       voice_i,
    input  logic        [1:0]       profile_i,
    output logic signed [ACC_W-1:0] weighted_o
);

    logic signed [ACC_W-1:0] half;
    logic signed [ACC_W-1:0] quarter;
    logic signed [ACC_W-1:0] eighth;

    assign half    = term_i >>> 1;
    assign quarter = term_i >>> 2;
    assign eighth  = term_i >>> 3;

    always_comb begin
        weighted_o = '0;
        unique case (profile_i)
            WGT_FUND: begin
                if (voice_i == 2'd0) weighted_o = term_i;
            end
            WGT_EVEN: begin
                case (voice_i)
                    2'd0:    weighted_o = half;
                    2'd1:    weighted_o = quarter;
                    2'd2:    weighted_o = quarter;
                    default: weighted_o = '0;
                endcase
            end
            WGT_SOFT: begin
                case (voice_i)
                    2'd0:    weighted_o = half + eighth;  // 5/8 as 1/2 + 1/8
                    2'd1:    weighted_o = quarter;
                    2'd2:    weighted_o = eighth;
                    default: weighted_o = '0;
                endcase
            end
            WGT_OCT: begin
                case (voice_i)
                    2'd0:    weighted_o = quarter;
                    2'd1:    weighted_o = half;
                    2'd2:    weighted_o = quarter;
                    default: weighted_o = '0;
                endcase
            end
            default: weighted_o = '0;
        endcase
    end

endmodule

// File: rtl/harmonic_scheduler.sv
// harmonic_scheduler: shares one quarter-wave sine ROM (1-cycle latency) across three harmonic
// phase accumulators (1x, 2x, 3x) and mixes them into one saturated signed sample per tick.
//   clk, reset (async, active low)
//   play_enable, generate_next_sample  start a sequence when both high and not busy
//   note_start     zeroes phases (deferred to the end of an in-flight sequence)
//   step_size      fundamental phase increment; weight selects the mix profile
//   rom_addr/rom_data  shared ROM port
//   sample_out, sample_ready, busy
//   overrun        only with HARMONIC_OVERRUN_FLAG_EN: sticky, set by a pulse while busy
module harmonic_scheduler
    import harmonic_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                play_enable,
    input  logic                generate_next_sample,
    input  logic                note_start,
    input  logic [STEP_W-1:0]   step_size,
    input  logic [1:0]          weight,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_data,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_ready,
    output logic                busy
`ifdef HARMONIC_OVERRUN_FLAG_EN
    ,
    output logic                overrun
`endif
);

    state_t                  state_q, state_d;
    logic [PHASE_W-1:0]      phase_q [NUM_HARM];
    logic [PHASE_W-1:0]      phase_d [NUM_HARM];
    logic [STEP_W-1:0]       step_q, step_d;
    logic [1:0]              weight_q, weight_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [SAMPLE_W-1:0]     sample_q, sample_d;
    logic                    ready_q, ready_d;
    logic                    pending_q, pending_d;

    logic [1:0]              voice;
    logic                    is_addr;
    logic                    is_cap;
    logic [PHASE_W-1:0]      cur_phase;
    logic [PHASE_W-1:0]      cur_step;
    logic signed [ACC_W-1:0] data_ext;
    logic signed [ACC_W-1:0] rom_term;
    logic signed [ACC_W-1:0] weighted;
    logic                    start;

    always_comb begin
        voice   = 2'd0;
        is_addr = 1'b0;
        is_cap  = 1'b0;
        case (state_q)
            ST_ADDR0: begin voice = 2'd0; is_addr = 1'b1; end
            ST_CAP0:  begin voice = 2'd0; is_cap  = 1'b1; end
            ST_ADDR1: begin voice = 2'd1; is_addr = 1'b1; end
            ST_CAP1:  begin voice = 2'd1; is_cap  = 1'b1; end
            ST_ADDR2: begin voice = 2'd2; is_addr = 1'b1; end
            ST_CAP2:  begin voice = 2'd2; is_cap  = 1'b1; end
            default:  ;
        endcase
    end

    always_comb begin
        cur_phase = phase_q[0];
        cur_step  = PHASE_W'(step_q);
        case (voice)
            2'd1: begin
                cur_phase = phase_q[1];
                cur_step  = PHASE_W'({step_q, 1'b0});
            end
            2'd2: begin
                cur_phase = phase_q[2];
                cur_step  = PHASE_W'(step_q) + PHASE_W'({step_q, 1'b0});
            end
            default: ;
        endcase
    end

    assign rom_addr = is_addr ? quad_addr(cur_phase[PHASE_W-2], cur_phase[PHASE_W-3 -: ROM_AW])
                              : '0;

    // Phase is unchanged during CAPv, so its quadrant still matches the data being returned.
    assign data_ext = $signed(ACC_W'(rom_data));
    assign rom_term = cur_phase[PHASE_W-1] ? -data_ext : data_ext;

    harmonic_weight u_weight (
        .term_i     (rom_term),
        .voice_i    (voice),
        .profile_i  (weight_q),
        .weighted_o (weighted)
    );

    assign busy  = (state_q != ST_IDLE) || ready_q;
    assign start = !busy && generate_next_sample && play_enable;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        step_d    = step_q;
        weight_d  = weight_q;
        acc_d     = acc_q;
        sample_d  = sample_q;
        ready_d   = 1'b0;
        pending_d = pending_q;

        if (state_q == ST_IDLE) begin
            if (note_start) begin
                for (int unsigned v = 0; v < NUM_HARM; v++) phase_d[v] = '0;
            end
            if (start) begin
                step_d   = step_size;
                weight_d = weight;
                acc_d    = '0;
                state_d  = ST_ADDR0;
            end
        end else begin
            if (note_start) pending_d = 1'b1;
            if (is_cap) begin
                acc_d = acc_q + weighted;
                case (voice)
                    2'd0:    phase_d[0] = cur_phase + cur_step;
                    2'd1:    phase_d[1] = cur_phase + cur_step;
                    default: phase_d[2] = cur_phase + cur_step;
                endcase
            end
            if (state_q == ST_DONE) begin
                state_d  = ST_IDLE;
                sample_d = saturate(acc_q);
                ready_d  = 1'b1;
                if (pending_q || note_start) begin
                    for (int unsigned v = 0; v < NUM_HARM; v++) phase_d[v] = '0;
                    pending_d = 1'b0;
                end
            end else begin
                state_d = state_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            for (int unsigned v = 0; v < NUM_HARM; v++) phase_q[v] <= '0;
            step_q    <= '0;
            weight_q  <= '0;
            acc_q     <= '0;
            sample_q  <= '0;
            ready_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            step_q    <= step_d;
            weight_q  <= weight_d;
            acc_q     <= acc_d;
            sample_q  <= sample_d;
            ready_q   <= ready_d;
            pending_q <= pending_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_ready = ready_q;

`ifdef HARMONIC_OVERRUN_FLAG_EN
    logic overrun_q, overrun_d;

    assign overrun_d = overrun_q | (generate_next_sample & play_enable & busy);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_harmonic_scheduler.sv
// tb_harmonic_scheduler: directed self-checking bench for harmonic_scheduler with a registered
// ROM stub (constant value or address echo).
module tb_harmonic_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        play_enable;
    logic        generate_next_sample;
    logic        note_start;
    logic [19:0] step_size;
    logic [1:0]  weight;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] sample_out;
    logic        sample_ready;
    logic        busy;
`ifdef HARMONIC_OVERRUN_FLAG_EN
    logic        overrun;
`endif

    harmonic_scheduler dut (
        .clk                  (clk),
        .reset                (reset),
        .play_enable          (play_enable),
        .generate_next_sample (generate_next_sample),
        .note_start           (note_start),
        .step_size            (step_size),
        .weight               (weight),
        .rom_addr             (rom_addr),
        .rom_data             (rom_data),
        .sample_out           (sample_out),
        .sample_ready         (sample_ready),
        .busy                 (busy)
`ifdef HARMONIC_OVERRUN_FLAG_EN
        ,
        .overrun              (overrun)
`endif
    );

    always #5 clk = ~clk;

    logic        rom_mode;  // 1: echo address, 0: constant
    logic [15:0] rom_val;
    always @(posedge clk) rom_data <= rom_mode ? {6'b0, rom_addr} : rom_val;

    int          n_checks = 0;
    int          n_err = 0;
    int          lat;
    int          n_ready;
    int          cnt;
    logic [9:0]  a0, a1, a2;
    logic [15:0] out_at_ready;
    logic [15:0] out_rst;
    logic        busy_at_ready, busy_after, busy_rst;

    logic [9:0]  exp_a [4][3] = '{'{10'h000, 10'h000, 10'h000},
                                  '{10'h200, 10'h3FF, 10'h1FF},
                                  '{10'h3FF, 10'h000, 10'h3FF},
                                  '{10'h1FF, 10'h3FF, 10'h200}};
    logic [15:0] exp_s [4] = '{16'h0000, 16'h0200, 16'h03FF, 16'h01FF};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; issues one start pulse and watches 12 cycles after E0.
    // inj_kind: 1 = second pulse plus step/weight change, 2 = note_start with play_enable
    // dropped, 3 = reset pulse.
    task automatic run_sample(input logic [19:0] st, input logic [1:0] w, input logic ns,
                              input int inj_k, input int inj_kind);
        lat = -1;
        n_ready = 0;
        busy_at_ready = 1'b0;
        busy_after = 1'b1;
        generate_next_sample = 1'b1;
        play_enable = 1'b1;
        step_size = st;
        weight = w;
        note_start = ns;
        @(negedge clk);
        generate_next_sample = 1'b0;
        note_start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            case (k)
                1: a0 = rom_addr;
                3: a1 = rom_addr;
                5: a2 = rom_addr;
                default: ;
            endcase
            if (sample_ready) begin
                n_ready++;
                if (lat < 0) begin
                    lat = k - 1;
                    out_at_ready = sample_out;
                    busy_at_ready = busy;
                end
            end
            if (lat >= 0 && k == lat + 2) busy_after = busy;
            if (k == inj_k) begin
                case (inj_kind)
                    1: begin
                        generate_next_sample = 1'b1;
                        play_enable = 1'b1;
                        weight = 2'd0;
                        step_size = 20'hFFFFF;
                    end
                    2: begin
                        note_start = 1'b1;
                        play_enable = 1'b0;
                    end
                    3: reset = 1'b0;
                    default: ;
                endcase
            end else if (k == inj_k + 1) begin
                generate_next_sample = 1'b0;
                note_start = 1'b0;
                if (inj_kind == 3) begin
                    busy_rst = busy;
                    out_rst = sample_out;
                end
            end else if (k == inj_k + 2 && inj_kind == 3) begin
                reset = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0;
        play_enable = 1'b0;
        generate_next_sample = 1'b0;
        note_start = 1'b0;
        step_size = '0;
        weight = '0;
        rom_mode = 1'b0;
        rom_val = 16'd1000;
        repeat (3) @(negedge clk);

        check("rst_sample_out", {16'b0, sample_out}, 32'h0);
        check("rst_ready", {31'b0, sample_ready}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_rom_addr", {22'b0, rom_addr}, 32'h0);
`ifdef HARMONIC_OVERRUN_FLAG_EN
        check("rst_overrun", {31'b0, overrun}, 32'h0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Basic sample: weight 0, ROM 1000.
        run_sample(20'h0, 2'd0, 1'b0, 0, 0);
        check("t1_latency", lat, 32'd7);
        check("t1_ready_count", n_ready, 32'd1);
        check("t1_sample", {16'b0, out_at_ready}, 32'd1000);
        check("t1_a0", {22'b0, a0}, 32'h0);
        check("t1_busy_ready", {31'b0, busy_at_ready}, 32'h1);
        check("t1_busy_after", {31'b0, busy_after}, 32'h0);

        // Weight 2, ROM 8000: 5000 + 2000 + 1000.
        rom_val = 16'd8000;
        run_sample(20'h0, 2'd2, 1'b0, 0, 0);
        check("t2_sample", {16'b0, out_at_ready}, 32'd8000);
        check("t2_a1", {22'b0, a1}, 32'h0);
        check("t2_a2", {22'b0, a2}, 32'h0);

        // Disabled pulse is ignored.
        generate_next_sample = 1'b1;
        play_enable = 1'b0;
        step_size = 20'h12345;
        @(negedge clk);
        generate_next_sample = 1'b0;
        check("dis_busy", {31'b0, busy}, 32'h0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (sample_ready) cnt++;
        end
        check("dis_ready_count", cnt, 32'd0);
        check("dis_sample_hold", {16'b0, sample_out}, 32'd8000);

        // Four pulses at step 0x80000 with address-echo ROM.
        rom_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_sample(20'h80000, 2'd0, 1'b0, 0, 0);
            check($sformatf("ph%0d_a0", i), {22'b0, a0}, {22'b0, exp_a[i][0]});
            check($sformatf("ph%0d_a1", i), {22'b0, a1}, {22'b0, exp_a[i][1]});
            check($sformatf("ph%0d_a2", i), {22'b0, a2}, {22'b0, exp_a[i][2]});
            check($sformatf("ph%0d_sample", i), {16'b0, out_at_ready}, {16'b0, exp_s[i]});
        end

        // Voice 0 now in q2: -32767 with no wrap.
        rom_mode = 1'b0;
        rom_val = 16'd32767;
        run_sample(20'h80000, 2'd0, 1'b0, 0, 0);
        check("q2_a0", {22'b0, a0}, 32'h0);
        check("q2_sample", {16'b0, out_at_ready}, 32'h8001);

        // q2/q1/q3 under weight 1: -16384 + 8191 - 8192 = -16385.
        run_sample(20'h80000, 2'd1, 1'b0, 0, 0);
        check("floor_sample", {16'b0, out_at_ready}, 32'hBFFF);

        // Zero phases in idle, walk into q3/q3/q2, then sum -32768 saturates to -32767.
        note_start = 1'b1;
        @(negedge clk);
        note_start = 1'b0;
        for (int i = 0; i < 4; i++) run_sample(20'hE0000, 2'd0, 1'b0, 0, 0);
        run_sample(20'h0, 2'd1, 1'b0, 0, 0);
        check("sat_a0", {22'b0, a0}, 32'h1FF);
        check("sat_a1", {22'b0, a1}, 32'h3FF);
        check("sat_a2", {22'b0, a2}, 32'h200);
        check("sat_sample", {16'b0, out_at_ready}, 32'h8001);
`ifdef HARMONIC_OVERRUN_FLAG_EN
        check("ovr_clear_before", {31'b0, overrun}, 32'h0);
`endif

        // note_start at CAP1 with play_enable dropped: completes, phases zero afterwards.
        rom_val = 16'd1000;
        run_sample(20'h12345, 2'd0, 1'b0, 4, 2);
        check("ns_cap1_latency", lat, 32'd7);
        check("ns_cap1_ready_count", n_ready, 32'd1);
        run_sample(20'h40000, 2'd0, 1'b0, 0, 0);
        check("ns_next_a0", {22'b0, a0}, 32'h0);
        check("ns_next_a1", {22'b0, a1}, 32'h0);
        check("ns_next_a2", {22'b0, a2}, 32'h0);
        check("ns_next_sample", {16'b0, out_at_ready}, 32'd1000);

        // Coincident note_start zeroes first; second pulse at E3 dropped; weight 3 latched.
        rom_val = 16'd1001;
        run_sample(20'h0, 2'd3, 1'b1, 3, 1);
        check("co_a0", {22'b0, a0}, 32'h0);
        check("co_a1", {22'b0, a1}, 32'h0);
        check("co_a2", {22'b0, a2}, 32'h0);
        check("drop_ready_count", n_ready, 32'd1);
        check("drop_sample", {16'b0, out_at_ready}, 32'd1000);
`ifdef HARMONIC_OVERRUN_FLAG_EN
        check("ovr_set", {31'b0, overrun}, 32'h1);
`endif
        rom_val = 16'd1000;
        run_sample(20'h0, 2'd0, 1'b0, 0, 0);
        check("latched_step_a1", {22'b0, a1}, 32'h0);
        check("latched_step_a2", {22'b0, a2}, 32'h0);
        check("after_drop_sample", {16'b0, out_at_ready}, 32'd1000);
`ifdef HARMONIC_OVERRUN_FLAG_EN
        check("ovr_sticky", {31'b0, overrun}, 32'h1);
`endif

        // Reset at CAP1 aborts the sequence.
        run_sample(20'h40000, 2'd0, 1'b0, 4, 3);
        check("rst_mid_busy", {31'b0, busy_rst}, 32'h0);
        check("rst_mid_sample", {16'b0, out_rst}, 32'h0);
        check("rst_mid_ready_count", n_ready, 32'd0);
`ifdef HARMONIC_OVERRUN_FLAG_EN
        check("ovr_reset", {31'b0, overrun}, 32'h0);
`endif
        run_sample(20'h0, 2'd0, 1'b0, 0, 0);
        check("post_rst_latency", lat, 32'd7);
        check("post_rst_a0", {22'b0, a0}, 32'h0);
        check("post_rst_sample", {16'b0, out_at_ready}, 32'd1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/harmonic_scheduler.md
Name: harmonic_scheduler

Overview:
Time-multiplexes one shared quarter-wave sine ROM (1024 x 16, 1-cycle read latency) across three harmonic phase accumulators: fundamental, 2x and 3x.
On each enabled sample pulse it sequences three ROM reads, applies quadrant symmetry and a selectable weight profile, and accumulates one mixed sample.
Sits between the note player's sample tick and the codec path. It replaces three private sine readers with one ROM port.

Parameters:
NUM_HARM, 3, harmonic voices sequenced per sample; fixed at 3, weight table is sized for it
PHASE_W, 22, phase accumulator width: [21:20] quadrant, [19:10] ROM address, [9:0] fraction
ROM_LAT, 1, ROM read latency in cycles; only 1 is supported

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
play_enable  in  1  gates sample pulses
generate_next_sample  in  1  single-cycle sample tick
note_start  in  1  single-cycle pulse; zeroes all three phases
step_size  in  20  fundamental phase increment
weight  in  2  weight profile select
rom_addr  out  10  shared sine ROM address
rom_data  in  16  ROM output, non-negative, valid one cycle after rom_addr
sample_out  out  16  signed mixed sample
sample_ready  out  1  one-cycle pulse when sample_out updates
busy  out  1  high while a sequence is in flight

Behaviour:
- Reset (reset low, async):
  - state IDLE; all phases 0; sample_out 0; sample_ready 0; busy 0; rom_addr 0; pending note_start cleared.
- Start condition: in IDLE, the edge that samples generate_next_sample=1 and play_enable=1 (edge E0):
  - latches step_size and weight;
  - clears the accumulator;
  - goes to ADDR0.
  - busy is high from E0 until the cycle after sample_ready.
- Voice steps (v=0..2):
  - step_v = step_size, step_size<<1, step_size+(step_size<<1) respectively, zero-extended to PHASE_W.
  - ADDRv: rom_addr is driven from phase_v.
  - CAPv: rom_data is valid. At the end of CAPv:
    - the weighted term is added to the accumulator;
    - phase_v <= phase_v + step_v (wraps modulo 2^22).
- Sequence and timing: IDLE->ADDR0->CAP0->ADDR1->CAP1->ADDR2->CAP2->DONE->IDLE.
  - sample_out and sample_ready update at E7, so sample_ready is high in the cycle after E7 for exactly one cycle.
- Quadrant handling:
  - q0: addr = p[19:10], +data
  - q1: addr = ~p[19:10], +data
  - q2: addr = p[19:10], -data
  - q3: addr = ~p[19:10], -data
  - Negation is performed in 18-bit signed.
- Weight profiles (shift-add only, terms for v0/v1/v2):
  - 0: 1, 0, 0
  - 1: 1/2, 1/4, 1/4
  - 2: 5/8, 1/4, 1/8
  - 3: 1/4, 1/2, 1/4
- Arithmetic:
  - Shifts are arithmetic; truncation is toward -inf.
  - Accumulator is 18-bit signed.
  - sample_out saturates to [-32767, +32767].
- play_enable low at a pulse: the pulse is ignored; phases, sample_out and sample_ready are unchanged.
- play_enable dropping mid-sequence: the sequence completes normally.
- generate_next_sample while busy: the pulse is dropped and the in-flight sequence is unaffected.
- step_size / weight changes mid-sequence: no effect until the next start.
- note_start:
  - In IDLE: zeroes all phases on that edge.
  - While busy: held pending and applied at DONE, after the phase advances, so the next sample starts at phase 0.
  - Coincident with a start pulse in IDLE: phases are zeroed first, and that sequence reads phase 0.

Optional Feature:
- Macro: HARMONIC_OVERRUN_FLAG_EN.
- Defined: adds output port overrun (1 bit), a sticky flag.
  - Set on any enabled generate_next_sample received while busy.
  - Cleared only by reset.
- Undefined: no port; dropped pulses are silent.

Decomposition:
- Package harmonic_pkg holds:
  - PHASE_W, ROM_AW=10, SAMPLE_W=16, ACC_W=18;
  - state enum (IDLE, ADDR0..CAP2, DONE);
  - weight-profile constants.
- Sub-module harmonic_weight: combinational. Inputs: signed term, voice index, profile. Output: weighted 18-bit term.
- The FSM, phase registers and accumulator stay in harmonic_scheduler.

Test Plan:
- Reset, then a single enabled pulse with step_size=0, weight=0, ROM returning 1000 at addr 0 -> sample_ready exactly 7 edges after E0; sample_out=1000; all phases remain 0.
- weight=2, ROM stub returns 8000 for every address, all phases in q0 -> sample_out = 5000+2000+1000 = 8000.
- Phases preloaded into q2 via steps, ROM returns 32767, weight=0 -> sample_out=-32767, no wrap.
- step_size=20'h80000, four pulses -> voice0 phase sequence 0, 0x080000, 0x100000, 0x180000; rom_addr mirrored in q1/q3.
- Second pulse at E3 of a sequence -> exactly one sample_ready; overrun=1 with HARMONIC_OVERRUN_FLAG_EN; overrun stays 1 until reset.
- note_start at CAP1 -> all phases 0 after DONE; next sample reads addr 0 for every voice. Reset asserted at CAP1 -> busy=0 and no sample_ready.
